// File: rtl/bpsk_symbol_serializer_if.sv
// Handshake bundle between the BPSK modulator, the serializer and the channel stage.
// The word side is in_*, the symbol side is sym_*.
interface bpsk_symbol_serializer_if #(parameter int N = 12);
    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   in_data;
    logic             sym_valid;
    logic             sym_ready;
    logic [1:0]       sym_out;
    logic             sym_first;
    logic             sym_last;
    logic             sym_err;

    modport master (
        output in_valid, in_data, sym_ready,
        input  in_ready, sym_valid, sym_out, sym_first, sym_last, sym_err
    );

    modport slave (
        input  in_valid, in_data, sym_ready,
        output in_ready, sym_valid, sym_out, sym_first, sym_last, sym_err
    );
endinterface

// File: rtl/bpsk_symbol_serializer.sv
// Serializes N-symbol BPSK words into one 2-bit symbol per clock.
// Holds one word ahead in a pending register so consecutive words stream without gaps.
module bpsk_symbol_serializer #(
    parameter int N = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bpsk_symbol_serializer_if.slave  bus,
    output logic                     busy,
    output logic [15:0]              word_count
);
    localparam int W  = 2 * N;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t          state_reg, state_next;
    logic [W-1:0]    act_reg, act_next;
    logic [W-1:0]    pend_reg, pend_next;
    logic            pend_v_reg, pend_v_next;
    logic [IW-1:0]   idx_reg, idx_next;
    logic [15:0]     count_reg, count_next;

    logic            accept;
    logic            sym_hs;
    logic            word_done;

    assign accept    = bus.in_valid && !pend_v_reg;
    assign sym_hs    = (state_reg == SHIFT) && bus.sym_ready;
    assign word_done = sym_hs && (idx_reg == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // SHIFT persists across word boundaries whenever another word is ready to load.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (word_done && !pend_v_reg && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = !pend_v_reg;
        bus.sym_valid = (state_reg == SHIFT);
        bus.sym_out   = act_reg[1:0];
        bus.sym_first = (idx_reg == '0);
        bus.sym_last  = (idx_reg == LAST_IDX);
        bus.sym_err   = (state_reg == SHIFT) && !act_reg[0];
        busy          = (state_reg == SHIFT) || pend_v_reg;
        word_count    = count_reg;
    end

    always_comb begin
        act_next    = act_reg;
        idx_next    = idx_reg;
        pend_next   = pend_reg;
        pend_v_next = pend_v_reg;
        count_next  = count_reg;
        if (state_reg == IDLE) begin
            if (accept) begin
                act_next = bus.in_data;
                idx_next = '0;
            end
        end else begin
            if (sym_hs && !word_done) begin
                act_next = act_reg >> 2;
                idx_next = idx_reg + 1'b1;
            end
            if (word_done) begin
                count_next = count_reg + 16'd1;
                idx_next   = '0;
                // in_ready is low whenever pend is full, so accept and pend_v never coincide here.
                if (pend_v_reg) begin
                    act_next    = pend_reg;
                    pend_v_next = 1'b0;
                end else if (accept) begin
                    act_next = bus.in_data;
                end
            end else if (accept) begin
                pend_next   = bus.in_data;
                pend_v_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_reg    <= '0;
            idx_reg    <= '0;
            pend_reg   <= '0;
            pend_v_reg <= 1'b0;
            count_reg  <= '0;
        end else begin
            act_reg    <= act_next;
            idx_reg    <= idx_next;
            pend_reg   <= pend_next;
            pend_v_reg <= pend_v_next;
            count_reg  <= count_next;
        end
    end
endmodule
